// File: rtl/ubbe_pkg.sv
// Shared encodings and pattern constants for the ubbe LED bank controller.
package ubbe_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [7:0] SCAN_INIT = 8'h01;
    localparam logic [7:0] LED_CLEAR = 8'h00;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_COUNT: next_mode = MODE_SCAN;
            MODE_SCAN:  next_mode = MODE_BLINK;
            MODE_BLINK: next_mode = MODE_OFF;
            default:    next_mode = MODE_COUNT;
        endcase
    endfunction

    // Pattern loaded on the edge a mode is entered.
    function automatic logic [7:0] init_led(input mode_e m);
        init_led = (m == MODE_SCAN) ? SCAN_INIT : LED_CLEAR;
    endfunction

endpackage

// File: rtl/ubbe_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw push button.
module ubbe_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES) begin
            // Flip and clear together; only a rising flip is a press.
            level_d = ~level_q;
            cnt_d   = '0;
            press_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/ubbe_led_ctrl.sv
// LED bank controller: step prescaler, two debounced buttons and the
// mode/pause FSM driving the registered LED pattern.
module ubbe_led_ctrl
    import ubbe_pkg::*;
#(
    parameter logic [31:0] TICK_DIV        = 32'h0100000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic       tick
);

    logic [31:0] div_q, div_d;
    logic        tick_q, tick_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  led_q, led_d;
    logic        dir_q, dir_d;
    logic        paused_q, paused_d;

    logic mode_press, pause_press;
    logic mode_level, pause_level;

    ubbe_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    ubbe_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_pause),
        .level (pause_level),
        .press (pause_press)
    );

    // Levels are kept for board-level debug taps; the FSM only needs pulses.
    logic unused_levels;
    assign unused_levels = mode_level ^ pause_level;

    always_comb begin
        div_d  = (div_q == TICK_DIV) ? '0 : div_q + 32'd1;
        tick_d = (div_q == TICK_DIV);
    end

    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_d    = dir_q;
        // Old paused value gates this cycle's step; the toggle applies next.
        paused_d = paused_q ^ pause_press;
        if (mode_press) begin
            mode_d = next_mode(mode_q);
            led_d  = init_led(next_mode(mode_q));
            dir_d  = DIR_LEFT;
        end else if (tick_q && !paused_q) begin
            case (mode_q)
                MODE_COUNT: led_d = led_q + 8'd1;
                MODE_SCAN: begin
                    if (dir_q == DIR_LEFT) begin
                        led_d = {led_q[6:0], 1'b0};
                        if (led_q[6]) dir_d = DIR_RIGHT;
                    end else begin
                        led_d = {1'b0, led_q[7:1]};
                        if (led_q[1]) dir_d = DIR_LEFT;
                    end
                end
                MODE_BLINK: led_d = ~led_q;
                default:    led_d = LED_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            mode_q   <= MODE_COUNT;
            led_q    <= LED_CLEAR;
            dir_q    <= DIR_LEFT;
            paused_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;
    assign tick   = tick_q;

endmodule

// File: doc/ubbe_led_ctrl.md
Name: ubbe_led_ctrl

Overview:
Controller for the 8-bit LED bank on the ubbefpga board. It does three things:
- Generates the pattern step tick.
- Debounces two push buttons: mode and pause.
- Runs a mode FSM that sequences the LED bank through counter, scanner, blink and off patterns.

It sits between the raw board I/O (buttons, LEDs) and the top level, and it owns the LED register.

Parameters:
- TICK_DIV, 32'h0100000, cycles per pattern step minus one (tick period = TICK_DIV+1 cycles).
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a debounced level changes.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_mode  input  1  raw, asynchronous mode button, high = pressed.
- btn_pause  input  1  raw, asynchronous pause button, high = pressed.
- led  output  8  LED bank drive, registered.
- mode  output  2  current mode, registered.
- paused  output  1  pause flag, registered.
- tick  output  1  registered one-cycle step pulse.

Behaviour:
- Reset values (asserted immediately on reset rising, independent of clk):
  - led=8'h00, mode=2'd0, paused=0, tick=0.
  - Prescaler counter=0, scan direction=left.
  - Synchronizer flops, debounce counters and debounced levels all 0.
- Prescaler:
  - 32-bit counter counts 0..TICK_DIV, then wraps to 0.
  - tick=1 for exactly the cycle after the counter equals TICK_DIV.
  - Free-running; not affected by pause or mode changes.
- Button path (each button):
  - 2-flop synchronizer feeding a debouncer.
  - The debounce counter increments while the synced input differs from the debounced level, and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A debounced 0->1 transition gives a 1-cycle press pulse.
  - Latency from a clean raw edge to the press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Mode FSM, on mode press: COUNT(0) -> SCAN(1) -> BLINK(2) -> OFF(3) -> COUNT(0).
  - On entry, led loads the initial pattern on the same edge the mode updates: COUNT 8'h00, SCAN 8'h01 with direction=left, BLINK 8'h00, OFF 8'h00.
- Pause press toggles paused. Mode presses are honoured while paused, and the initial pattern still loads.
- Pattern step (on a registered tick with paused=0):
  - COUNT: led = led+1, modulo 256 (8'hFF -> 8'h00).
  - SCAN: left shift until 8'h80, then direction reverses and shifts right until 8'h01, then reverses again. Endpoints are hit once per pass: 8'h40 -> 8'h80 -> 8'h40, and 8'h02 -> 8'h01 -> 8'h02.
  - BLINK: led = ~led (8'h00 <-> 8'hFF).
  - OFF: led holds 8'h00.
- Simultaneous events:
  - Mode press and tick in the same cycle: the mode change wins and that tick's step is dropped.
  - Pause press and tick in the same cycle: the new paused value governs the next tick only; the current tick steps if paused was 0 before the toggle.
  - Mode press and pause press together: both take effect.
- Reset mid-operation returns every output to its reset value. On release, the prescaler restarts from 0, so the first tick appears after TICK_DIV+1 cycles.
- Held buttons produce exactly one press pulse. Bounces shorter than DEBOUNCE_CYCLES produce no pulse.

Decomposition:
- Package ubbe_pkg holds:
  - Mode encodings MODE_COUNT=2'd0, MODE_SCAN=2'd1, MODE_BLINK=2'd2, MODE_OFF=2'd3.
  - Scan direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Initial pattern constants SCAN_INIT=8'h01 and LED_CLEAR=8'h00.
- One sub-module, ubbe_debounce: synchronizer, debounce counter, debounced level and press pulse. Parameter DEBOUNCE_CYCLES; ports clk, reset, btn, level, press. Instantiated twice.
- Prescaler, FSM and pattern datapath stay in ubbe_led_ctrl.

Test Plan:
All scenarios use TICK_DIV=3 and DEBOUNCE_CYCLES=4.
1. Reset release, no buttons, 20 ticks -> tick every 4 cycles; led counts 8'h01..8'h14; mode=0, paused=0.
2. 256 ticks in COUNT from 8'h00 -> led wraps 8'hFF -> 8'h00.
3. One clean mode press (held 10 cycles) -> press pulse 7 cycles after the raw edge; mode=1, led=8'h01. Then 14 ticks -> led 02,04,08,10,20,40,80,40,20,10,08,04,02,01.
4. Raw btn_mode glitches of 1-3 cycles, separated by low gaps -> no mode change. Mode press timed to land on a tick cycle -> mode advances, no pattern step on that tick.
5. Pause press in BLINK with led=8'hFF, then 5 ticks -> led holds 8'hFF. Second pause press -> next tick gives led=8'h00.
6. Mode presses 0->1->2->3->0 with reset asserted mid-debounce on the third press -> all outputs 0 immediately. First tick after release comes 4 cycles later, and no stale press pulse appears.
